// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory (1-cycle read latency)
// between an instruction-fetch port (IF) and a load/store port (LS).
//
// Ports:
//   clk_i, rst_i           clock; asynchronous active-high reset
//   if_req_i/if_addr_i     fetch request and byte address
//   if_flush_i             squash fetch: blocks the fetch grant, drops a pending fetch response
//   if_gnt_o               fetch granted this cycle (combinational)
//   if_rvalid_o/if_rdata_o fetch response, one cycle after the grant
//   ls_req_i/ls_we_i       load/store request, 1=store
//   ls_be_i/ls_addr_i      store byte enables and byte address
//   ls_wdata_i             store data
//   ls_gnt_o               load/store granted this cycle (combinational)
//   ls_rvalid_o/ls_rdata_o load response, one cycle after the grant
//   mem_*_o                memory command, driven by the granted requester (all 0 when idle)
//   mem_rdata_i            memory read data, valid the cycle after a read
//
// LS has priority, but a fetch denied STARVE_LIMIT cycles in a row is forced to
// win once. resp_owner remembers who issued the read now in flight so that
// mem_rdata_i is steered to the right port.
module mem_arbiter #(
  parameter int DW           = 32,
  parameter int AW           = 32,
  parameter int BEW          = DW / 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           if_req_i,
  input  logic [AW-1:0]  if_addr_i,
  input  logic           if_flush_i,
  output logic           if_gnt_o,
  output logic           if_rvalid_o,
  output logic [DW-1:0]  if_rdata_o,
  input  logic           ls_req_i,
  input  logic           ls_we_i,
  input  logic [BEW-1:0] ls_be_i,
  input  logic [AW-1:0]  ls_addr_i,
  input  logic [DW-1:0]  ls_wdata_i,
  output logic           ls_gnt_o,
  output logic           ls_rvalid_o,
  output logic [DW-1:0]  ls_rdata_o,
  output logic           mem_en_o,
  output logic           mem_we_o,
  output logic [BEW-1:0] mem_be_o,
  output logic [AW-1:0]  mem_addr_o,
  output logic [DW-1:0]  mem_wdata_o,
  input  logic [DW-1:0]  mem_rdata_i
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_e     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic       if_gnt, ls_gnt;

  // Arbitration. Reset forces both grants low so nothing reaches the memory.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!rst_i) begin
      if (ls_req_i && (starve_q < LIMIT)) begin
        ls_gnt = 1'b1;
      end else if (if_req_i && !if_flush_i) begin
        if_gnt = 1'b1;
      end else if (ls_req_i) begin
        ls_gnt = 1'b1;
      end
    end
  end

  assign if_gnt_o = if_gnt;
  assign ls_gnt_o = ls_gnt;

  // Memory command mux; loads always read the full word.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (ls_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = ls_we_i;
      mem_be_o    = ls_we_i ? ls_be_i : {BEW{1'b1}};
      mem_addr_o  = ls_addr_i;
      mem_wdata_o = ls_wdata_i;
    end else if (if_gnt) begin
      mem_en_o   = 1'b1;
      mem_addr_o = if_addr_i;
    end
  end

  // Counts consecutive cycles a live (unflushed) fetch was denied; saturates.
  always_comb begin
    starve_d = 4'd0;
    if (if_req_i && !if_gnt && !if_flush_i) begin
      starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
    end
  end

  // Stores complete at grant, so only reads claim the response slot.
  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (ls_gnt && !ls_we_i) begin
      owner_d = OWN_LS;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q  <= OWN_NONE;
      starve_q <= 4'd0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  // A flush in the response cycle discards the squashed fetch's data.
  assign if_rvalid_o = (owner_q == OWN_IF) && !if_flush_i;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign ls_rvalid_o = (owner_q == OWN_LS);
  assign ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i, if_flush_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i, ls_we_i;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_addr_i, ls_wdata_i;
  logic        ls_gnt_o, ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DW(32), .AW(32), .BEW(4), .STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    logic        ir;  logic [31:0] ia; logic fl;
    logic        lr;  logic lw; logic [3:0] lbe; logic [31:0] la; logic [31:0] lwd;
    logic [31:0] rd;
    logic        eig; logic elg;
    logic        een; logic ewe; logic [3:0] ebe; logic [31:0] eaddr; logic [31:0] ewd;
    logic        eiv; logic [31:0] eid;
    logic        elv; logic [31:0] eld;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus plus the grant/response outcome; the memory command
  // expected for a grant follows directly from which side was granted.
  task automatic add(input logic ir, input logic [31:0] ia, input logic fl,
                     input logic lr, input logic lw, input logic [3:0] lbe,
                     input logic [31:0] la, input logic [31:0] lwd, input logic [31:0] rd,
                     input logic eig, input logic elg,
                     input logic eiv, input logic [31:0] eid,
                     input logic elv, input logic [31:0] eld);
    vec_t v;
    v.ir = ir; v.ia = ia; v.fl = fl;
    v.lr = lr; v.lw = lw; v.lbe = lbe; v.la = la; v.lwd = lwd; v.rd = rd;
    v.eig = eig; v.elg = elg;
    v.eiv = eiv; v.eid = eid; v.elv = elv; v.eld = eld;
    v.een = 1'b0; v.ewe = 1'b0; v.ebe = 4'h0; v.eaddr = 32'h0; v.ewd = 32'h0;
    if (elg) begin
      v.een = 1'b1; v.ewe = lw; v.ebe = lw ? lbe : 4'hF; v.eaddr = la; v.ewd = lwd;
    end else if (eig) begin
      v.een = 1'b1; v.eaddr = ia;
    end
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    if_req_i = 0; if_addr_i = 0; if_flush_i = 0;
    ls_req_i = 0; ls_we_i = 0; ls_be_i = 0; ls_addr_i = 0; ls_wdata_i = 0;
  endtask

  initial begin
    string pat;
    logic  g_ls, g_if, pv_ls, pv_if;

    rst_i = 1'b1;
    idle_inputs();
    mem_rdata_i = 32'hFFFF_FFFF;

    // Reset state: requests pending while in reset must not be granted.
    @(negedge clk);
    if_req_i = 1; if_addr_i = 32'h10; ls_req_i = 1; ls_we_i = 1; ls_be_i = 4'hF;
    ls_addr_i = 32'h100; ls_wdata_i = 32'h1234_5678;
    @(posedge clk); @(negedge clk); #1;
    chk("rst if_gnt", if_gnt_o, 0);
    chk("rst ls_gnt", ls_gnt_o, 0);
    chk("rst mem_en", mem_en_o, 0);
    chk("rst mem_we", mem_we_o, 0);
    chk("rst mem_be", mem_be_o, 0);
    chk("rst mem_addr", mem_addr_o, 0);
    chk("rst mem_wdata", mem_wdata_o, 0);
    chk("rst if_rvalid", if_rvalid_o, 0);
    chk("rst if_rdata", if_rdata_o, 0);
    chk("rst ls_rvalid", ls_rvalid_o, 0);
    chk("rst ls_rdata", ls_rdata_o, 0);
    @(negedge clk);
    idle_inputs();
    rst_i = 1'b0;
    @(posedge clk);

    // Fetch only
    add(1, 32'h10, 0,  0, 0, 4'h0, 32'h0, 32'h0, 32'hAAAA_AAAA, 1, 0, 0, 32'h0, 0, 32'h0);
    add(0, 32'h0,  0,  0, 0, 4'h0, 32'h0, 32'h0, 32'h0040_0193, 0, 0, 1, 32'h0040_0193, 0, 32'h0);
    // Store: no response
    add(0, 32'h0,  0,  1, 1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 32'h1111_1111, 0, 1, 0, 32'h0, 0, 32'h0);
    add(0, 32'h0,  0,  0, 0, 4'h0, 32'h0, 32'h0, 32'h2222_2222, 0, 0, 0, 32'h0, 0, 32'h0);
    // Back-to-back load then fetch
    add(0, 32'h0,  0,  1, 0, 4'h0, 32'h200, 32'h0, 32'h3333_3333, 0, 1, 0, 32'h0, 0, 32'h0);
    add(1, 32'h14, 0,  0, 0, 4'h0, 32'h0, 32'h0, 32'hCAFE_F00D, 1, 0, 0, 32'h0, 1, 32'hCAFE_F00D);
    add(0, 32'h0,  0,  0, 0, 4'h0, 32'h0, 32'h0, 32'h1234_5678, 0, 0, 1, 32'h1234_5678, 0, 32'h0);
    // Flush drops the fetch response and blocks the fetch grant
    add(1, 32'h20, 0,  0, 0, 4'h0, 32'h0, 32'h0, 32'h5555_5555, 1, 0, 0, 32'h0, 0, 32'h0);
    add(1, 32'h24, 1,  0, 0, 4'h0, 32'h0, 32'h0, 32'h6666_6666, 0, 0, 0, 32'h0, 0, 32'h0);
    add(1, 32'h24, 0,  0, 0, 4'h0, 32'h0, 32'h0, 32'h7777_7777, 1, 0, 0, 32'h0, 0, 32'h0);
    add(0, 32'h0,  0,  0, 0, 4'h0, 32'h0, 32'h0, 32'h8888_8888, 0, 0, 1, 32'h8888_8888, 0, 32'h0);
    // Starvation: both request continuously, hand-derived grant pattern
    pat = "LLLLILLLLI";
    for (int k = 0; k < 10; k++) begin
      g_ls  = (pat[k] == "L");
      g_if  = (pat[k] == "I");
      pv_ls = (k > 0) && (pat[k-1] == "L");
      pv_if = (k > 0) && (pat[k-1] == "I");
      add(1, 32'h40, 0, 1, 0, 4'h0, 32'h300, 32'h0, 32'h1000 + 32'(k),
          g_if, g_ls, pv_if, pv_if ? 32'h1000 + 32'(k) : 32'h0,
          pv_ls, pv_ls ? 32'h1000 + 32'(k) : 32'h0);
    end
    add(0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h100A, 0, 0, 1, 32'h100A, 0, 32'h0);

    foreach (vq[i]) begin
      @(negedge clk);
      if_req_i = vq[i].ir; if_addr_i = vq[i].ia; if_flush_i = vq[i].fl;
      ls_req_i = vq[i].lr; ls_we_i = vq[i].lw; ls_be_i = vq[i].lbe;
      ls_addr_i = vq[i].la; ls_wdata_i = vq[i].lwd; mem_rdata_i = vq[i].rd;
      #1;
      chk($sformatf("row%0d if_gnt", i), if_gnt_o, vq[i].eig);
      chk($sformatf("row%0d ls_gnt", i), ls_gnt_o, vq[i].elg);
      chk($sformatf("row%0d mem_en", i), mem_en_o, vq[i].een);
      chk($sformatf("row%0d mem_we", i), mem_we_o, vq[i].ewe);
      chk($sformatf("row%0d mem_be", i), mem_be_o, vq[i].ebe);
      chk($sformatf("row%0d mem_addr", i), mem_addr_o, vq[i].eaddr);
      chk($sformatf("row%0d mem_wdata", i), mem_wdata_o, vq[i].ewd);
      chk($sformatf("row%0d if_rvalid", i), if_rvalid_o, vq[i].eiv);
      chk($sformatf("row%0d if_rdata", i), if_rdata_o, vq[i].eid);
      chk($sformatf("row%0d ls_rvalid", i), ls_rvalid_o, vq[i].elv);
      chk($sformatf("row%0d ls_rdata", i), ls_rdata_o, vq[i].eld);
    end

    // Reset asserted with a load in flight: its response must never appear.
    @(negedge clk);
    idle_inputs();
    ls_req_i = 1; ls_addr_i = 32'h400; mem_rdata_i = 32'h0;
    #1;
    chk("rr load gnt", ls_gnt_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rr gnt forced low", ls_gnt_o, 0);
    chk("rr mem_en low", mem_en_o, 0);
    @(negedge clk);
    mem_rdata_i = 32'hBEEF_0001;
    #1;
    chk("rr in-reset ls_rvalid", ls_rvalid_o, 0);
    chk("rr in-reset ls_rdata", ls_rdata_o, 0);
    chk("rr in-reset mem_addr", mem_addr_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    ls_req_i = 0;
    #1;
    chk("rr post ls_rvalid", ls_rvalid_o, 0);
    chk("rr post ls_rdata", ls_rdata_o, 0);
    @(negedge clk);
    if_req_i = 1; if_addr_i = 32'h50; mem_rdata_i = 32'hBEEF_0002;
    #1;
    chk("rr resume if_gnt", if_gnt_o, 1);
    chk("rr resume mem_addr", mem_addr_o, 32'h50);
    chk("rr resume ls_rvalid", ls_rvalid_o, 0);
    @(negedge clk);
    idle_inputs();
    mem_rdata_i = 32'h0000_0077;
    #1;
    chk("rr resume if_rvalid", if_rvalid_o, 1);
    chk("rr resume if_rdata", if_rdata_o, 32'h77);
    chk("rr resume ls_rvalid2", ls_rvalid_o, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port synchronous memory between the pipeline's instruction-fetch port and its load/store port. Arbitrates every cycle: data accesses have priority, and an anti-starvation counter guarantees fetch progress. Tracks the owner of each in-flight read so the response (1-cycle memory latency) returns to the correct requester. Supports a fetch flush so that squashed fetches on a taken branch or jump are dropped.

Parameters:
DW, 32, data width in bits
AW, 32, byte-address width
BEW, DW/8, byte-enable width
STARVE_LIMIT, 4, consecutive cycles a fetch may be denied before it is forced to win (1..15)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous, active-high reset
if_req_i  in  1  fetch request valid
if_addr_i  in  AW  fetch byte address
if_flush_i  in  1  fetch squash (taken branch/jump)
if_gnt_o  out  1  fetch granted this cycle
if_rvalid_o  out  1  fetch read data valid
if_rdata_o  out  DW  fetch read data
ls_req_i  in  1  load/store request valid
ls_we_i  in  1  1=store, 0=load
ls_be_i  in  BEW  store byte enables
ls_addr_i  in  AW  load/store byte address
ls_wdata_i  in  DW  store data
ls_gnt_o  out  1  load/store granted this cycle
ls_rvalid_o  out  1  load data valid
ls_rdata_o  out  DW  load data
mem_en_o  out  1  memory access enable
mem_we_o  out  1  memory write enable
mem_be_o  out  BEW  memory byte enables
mem_addr_o  out  AW  memory byte address (passed through unchanged; alignment is the requester's responsibility)
mem_wdata_o  out  DW  memory write data
mem_rdata_i  in  DW  memory read data, valid one cycle after a read with mem_en_o=1 and mem_we_o=0

Behaviour:
- Grant is combinational, at most one grant per cycle. A request is held until granted; the requester must keep the address and data stable while its request is pending.
- Priority:
  - if_flush_i=1 blocks the fetch grant that cycle.
  - Otherwise, if ls_req_i=1 and starve_cnt<STARVE_LIMIT, LS wins.
  - Otherwise, if if_req_i=1, IF wins.
  - Otherwise, LS wins if requesting.
- starve_cnt (4-bit, saturating at STARVE_LIMIT):
  - increments on a cycle with if_req_i & ~if_gnt_o & ~if_flush_i;
  - clears on a fetch grant, on if_req_i=0, or on if_flush_i=1.
- Memory drive follows the granted requester:
  - IF grant: en=1, we=0, be=0.
  - LS grant: en=1, we=ls_we_i, be=ls_be_i (be=all-ones for loads), plus address and wdata.
  - No grant: all mem_* outputs are 0.
- Owner register resp_owner ∈ {NONE, IF, LS}. Updated every edge:
  - IF for a fetch grant; LS for a load grant;
  - NONE for a store grant or no grant.
- Response cycle (one after the grant):
  - owner=IF and if_flush_i=0: if_rvalid_o=1, if_rdata_o=mem_rdata_i.
  - owner=IF and if_flush_i=1: response dropped, if_rvalid_o=0.
  - owner=LS: ls_rvalid_o=1, ls_rdata_o=mem_rdata_i.
  - rdata outputs are 0 whenever the matching rvalid is 0.
  - Stores complete at grant; they produce no ls_rvalid_o.
- Pipelining: grants are accepted back-to-back every cycle. A response and a new grant may occur in the same cycle.
- Reset: while rst_i=1, all outputs are 0 (grants are forced low), resp_owner=NONE, starve_cnt=0. Reset asserted with a read in flight drops that response; no rvalid appears after reset deasserts.

Test Plan:
1. Fetch only: if_req_i=1, if_addr_i=0x10, mem returns 0x00400193 → if_gnt_o=1 and mem_addr_o=0x10 in cycle N; if_rvalid_o=1 with if_rdata_o=0x00400193 in N+1.
2. Store: ls_req_i=1, ls_we_i=1, ls_be_i=4'b0011, addr 0x100, wdata 0xDEADBEEF → mem_we_o=1, mem_be_o=0011, ls_gnt_o=1 in N; ls_rvalid_o=0 in N+1.
3. Starvation, STARVE_LIMIT=4, both requesting continuously → LS granted cycles 0–3, IF granted cycle 4 (starve_cnt=4), LS granted cycle 5, IF granted again at cycle 9.
4. Back-to-back: load from 0x200 granted in N, fetch granted in N+1 → ls_rvalid_o in N+1, if_rvalid_o in N+2, no cross-delivery of data.
5. Flush: fetch granted in N, if_flush_i=1 in N+1 with if_req_i=1 → if_rvalid_o=0 and if_gnt_o=0 in N+1; fetch granted in N+2.
6. Reset mid-read: load granted in N, rst_i=1 across edge N+1 → all outputs 0, ls_rvalid_o never asserts; normal grants resume the cycle after rst_i falls.
